// File: rtl/step_sequencer.sv
// step_sequencer: phase-accumulator step clock with transport control and BPM clamping
module step_sequencer #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned STEPS_PER_BEAT = 2,
  parameter int unsigned ACC_W          = 32,
  parameter int unsigned MIN_BPM        = 30,
  parameter int unsigned MAX_BPM        = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic       stop,
  input  logic [7:0] bpm_in,
  input  logic       bpm_load,
  output logic       step_tick,
  output logic [2:0] timing,
  output logic       bar_start,
  output logic       playing,
  output logic [7:0] bpm_out
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam logic [ACC_W-1:0] T = ACC_W'(64'(CLK_HZ) * 64'd60);
  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] sum;
  logic [7:0]       bpm_active;
  logic [7:0]       bpm_shadow;
  logic [7:0]       bpm_clamped;
  assign bpm_clamped = bpm_in < 8'(MIN_BPM) ? 8'(MIN_BPM) : bpm_in > 8'(MAX_BPM) ? 8'(MAX_BPM) : bpm_in;
  assign inc         = ACC_W'(bpm_active) * ACC_W'(STEPS_PER_BEAT);
  assign sum         = acc + inc;
  assign bpm_out     = bpm_active;
  // transport FSM; a new rate is only adopted at a step boundary so step spacing never glitches
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      acc        <= '0;
      timing     <= '0;
      step_tick  <= 1'b0;
      bar_start  <= 1'b0;
      playing    <= 1'b0;
      bpm_active <= 8'd60;
      bpm_shadow <= 8'd60;
    end else begin
      step_tick <= 1'b0;
      bar_start <= 1'b0;
      if (bpm_load) bpm_shadow <= bpm_clamped;
      if (stop) begin
        state      <= IDLE;
        acc        <= '0;
        timing     <= '0;
        playing    <= 1'b0;
        bpm_active <= bpm_shadow;
      end else begin
        case (state)
          IDLE: begin
            acc    <= '0;
            timing <= '0;
            if (bpm_load) bpm_active <= bpm_clamped;
            if (play) begin
              state     <= RUN;
              step_tick <= 1'b1;
              bar_start <= 1'b1;
              playing   <= 1'b1;
            end
          end
          RUN: begin
            if (!play) begin
              state   <= PAUSE;
              playing <= 1'b0;
            end else if (sum >= T) begin
              acc        <= sum - T;
              step_tick  <= 1'b1;
              timing     <= timing + 3'd1;
              bar_start  <= timing == 3'd7;
              bpm_active <= bpm_load ? bpm_clamped : bpm_shadow;
            end else begin
              acc <= sum;
            end
          end
          PAUSE: begin
            if (play) begin
              state   <= RUN;
              playing <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed checks of step timing, BPM handling and transport control
module tb_step_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] bpm_in = 8'd0;
  logic       bpm_load = 1'b0;
  logic       step_tick;
  logic [2:0] timing;
  logic       bar_start;
  logic       playing;
  logic [7:0] bpm_out;
  int passed = 0;
  int total = 0;
  int n;
  int ticks;
  step_sequencer #(.CLK_HZ(60)) dut (
    .clk(clk), .reset(reset), .play(play), .stop(stop), .bpm_in(bpm_in), .bpm_load(bpm_load),
    .step_tick(step_tick), .timing(timing), .bar_start(bar_start), .playing(playing), .bpm_out(bpm_out)
  );
  always #5 clk = ~clk;
  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic tick_wait(output int cnt);
    cnt = 0;
    do begin
      step(1);
      cnt++;
    end while (!step_tick && cnt < 1000);
  endtask
  initial begin
    step(2);
    chk("rst_tick", step_tick, 0);
    chk("rst_timing", timing, 0);
    chk("rst_bar", bar_start, 0);
    chk("rst_playing", playing, 0);
    chk("rst_bpm", bpm_out, 60);
    reset = 1'b1;
    bpm_in = 8'd0; bpm_load = 1'b1;
    step(1);
    chk("clamp_low", bpm_out, 30);
    bpm_in = 8'd250;
    step(1);
    chk("clamp_high", bpm_out, 240);
    bpm_load = 1'b0;
    play = 1'b1;
    step(1);
    chk("entry240_tick", step_tick, 1);
    chk("entry240_bar", bar_start, 1);
    chk("entry240_timing", timing, 0);
    chk("entry240_playing", playing, 1);
    for (int i = 1; i <= 4; i++) begin
      tick_wait(n);
      chk("space240", n, (i % 2) ? 8 : 7);
      chk("timing240", timing, i);
    end
    play = 1'b0; stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stop_playing", playing, 0);
    chk("stop_timing", timing, 0);
    bpm_in = 8'd60; bpm_load = 1'b1;
    step(1);
    bpm_load = 1'b0;
    chk("load60", bpm_out, 60);
    play = 1'b1;
    step(1);
    chk("entry60_tick", step_tick, 1);
    chk("entry60_bar", bar_start, 1);
    chk("entry60_timing", timing, 0);
    step(1);
    chk("no_double_tick", step_tick, 0);
    tick_wait(n);
    chk("space60_first", n, 29);
    chk("timing60_first", timing, 1);
    for (int i = 2; i <= 8; i++) begin
      tick_wait(n);
      chk("space60", n, 30);
      chk("timing60", timing, i % 8);
      chk("bar60", bar_start, (i == 8) ? 1 : 0);
    end
    step(9);
    bpm_in = 8'd120; bpm_load = 1'b1;
    step(1);
    bpm_load = 1'b0;
    chk("bpm_held", bpm_out, 60);
    tick_wait(n);
    chk("space_to_change", n, 20);
    chk("bpm_changed", bpm_out, 120);
    chk("timing_change", timing, 1);
    for (int i = 2; i <= 3; i++) begin
      tick_wait(n);
      chk("space120", n, 15);
      chk("timing120", timing, i);
    end
    step(11);
    play = 1'b0;
    step(1);
    chk("pause_playing", playing, 0);
    ticks = 0;
    repeat (50) begin
      step(1);
      if (step_tick) ticks++;
    end
    chk("pause_ticks", ticks, 0);
    chk("pause_timing", timing, 3);
    play = 1'b1;
    tick_wait(n);
    chk("resume_space", n, 5);
    chk("resume_timing", timing, 4);
    tick_wait(n);
    chk("space_t5", n, 15);
    chk("timing_t5", timing, 5);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    chk("stopplay_tick", step_tick, 0);
    chk("stopplay_bar", bar_start, 0);
    chk("stopplay_timing", timing, 0);
    chk("stopplay_playing", playing, 0);
    chk("stopplay_bpm", bpm_out, 120);
    step(1);
    chk("restart_tick", step_tick, 1);
    chk("restart_bar", bar_start, 1);
    chk("restart_timing", timing, 0);
    chk("restart_playing", playing, 1);
    for (int i = 1; i <= 6; i++) tick_wait(n);
    chk("pre_reset_timing", timing, 6);
    reset = 1'b0;
    step(1);
    reset = 1'b1; play = 1'b0;
    chk("midrst_tick", step_tick, 0);
    chk("midrst_bar", bar_start, 0);
    chk("midrst_timing", timing, 0);
    chk("midrst_playing", playing, 0);
    chk("midrst_bpm", bpm_out, 60);
    step(3);
    chk("idle_after_rst", step_tick, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
